// File: rtl/bitcoin_hash_pkg.sv
// Shared constants, FSM states and SHA-256 round helpers for the parallel nonce hasher.
package bitcoin_hash_pkg;

  typedef enum logic [2:0] {IDLE, READ, MID, BLK2, HASH2, WRITE, DONE} state_t;

  // Element [i] holds word Hi of the initial hash value.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned r);
    return (x >> r) | (x << (32 - r));
  endfunction

  // One compression round; result packs a'..h' MSB-first.
  function automatic logic [255:0] sha256_op(
    input logic [31:0] a, b, c, d, e, f, g, h, w, k);
    logic [31:0] s0, s1, ch, maj, t1, t2;
    s1  = rightrotate(e, 6) ^ rightrotate(e, 11) ^ rightrotate(e, 25);
    ch  = (e & f) ^ (~e & g);
    t1  = h + s1 + ch + k + w;
    s0  = rightrotate(a, 2) ^ rightrotate(a, 13) ^ rightrotate(a, 22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t2  = s0 + maj;
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

endpackage

// File: rtl/bitcoin_hash_par_sha256_block.sv
// One 64-round SHA-256 compression engine: start runs round 0 from init_h/blk directly,
// rounds 1..63 follow one per cycle, and the 65th cycle adds init_h back in.
module sha256_block
  import bitcoin_hash_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0][31:0] init_h,
  input  logic [15:0][31:0] blk,
  output logic [7:0][31:0] digest
);

  logic [7:0][31:0]  st;
  logic [15:0][31:0] w;
  logic [6:0]        rnd;
  logic              run;

  logic [7:0][31:0]  cur_s, nxt_s;
  logic [15:0][31:0] cur_w;
  logic [31:0]       w_new;
  logic [255:0]      nxt;
  logic [5:0]        k_idx;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
  endfunction

  // Round 0 bypasses the registers so the engine needs no separate load cycle.
  always_comb begin
    cur_s = start ? init_h : st;
    cur_w = start ? blk : w;
    k_idx = start ? 6'd0 : rnd[5:0];
    w_new = sig1(cur_w[14]) + cur_w[9] + sig0(cur_w[1]) + cur_w[0];
    nxt   = sha256_op(cur_s[0], cur_s[1], cur_s[2], cur_s[3],
                      cur_s[4], cur_s[5], cur_s[6], cur_s[7], cur_w[0], K[k_idx]);
    for (int i = 0; i < 8; i++) nxt_s[i] = nxt[255-32*i -: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= '0;
      w   <= '0;
      rnd <= '0;
      run <= 1'b0;
    end else if (start) begin
      st  <= nxt_s;
      w   <= {w_new, cur_w[15:1]};
      rnd <= 7'd1;
      run <= 1'b1;
    end else if (run) begin
      if (rnd == 7'd64) begin
        for (int i = 0; i < 8; i++) st[i] <= st[i] + init_h[i];
        run <= 1'b0;
      end else begin
        st  <= nxt_s;
        w   <= {w_new, cur_w[15:1]};
        rnd <= rnd + 7'd1;
      end
    end
  end

  assign digest = st;

endmodule

// File: rtl/bitcoin_hash_par.sv
// Parallel double-SHA-256 nonce hasher: header fetch, shared midstate, NUM_CORES lockstep engines.
// Define BITCOIN_HASH_FULL_DIGEST_EN to write all eight digest words per nonce instead of H0 only.
module bitcoin_hash_par
  import bitcoin_hash_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int NUM_CORES  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_base,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

`ifdef BITCOIN_HASH_FULL_DIGEST_EN
  localparam int WPN = 8;
`else
  localparam int WPN = 1;
`endif
  localparam int BATCHES = NUM_NONCES / NUM_CORES;
  localparam int WR_LEN  = NUM_CORES * WPN;
  localparam logic [7:0] WR_LAST = 8'(WR_LEN - 1);
  localparam logic [8:0] B_LAST  = 9'(BATCHES - 1);

  state_t state, nstate;
  logic [7:0]  cnt;
  logic [8:0]  batch;
  logic [15:0] m_addr, o_addr;
  logic [31:0] n_base;
  logic [18:0][31:0] hdr;

  logic [NUM_CORES-1:0][7:0][31:0] digests;
  logic [7:0][31:0] mid_h, core_init;
  logic mid_start, core_start;

  assign mem_clk = clk;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (start) nstate = READ;
      READ:  if (cnt == 8'd19) nstate = MID;
      MID:   if (cnt == 8'd64) nstate = BLK2;
      BLK2:  if (cnt == 8'd64) nstate = HASH2;
      HASH2: if (cnt == 8'd64) nstate = WRITE;
      WRITE: if (cnt == WR_LAST) nstate = (batch == B_LAST) ? DONE : BLK2;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      batch  <= '0;
      m_addr <= '0;
      o_addr <= '0;
      n_base <= '0;
      hdr    <= '0;
    end else begin
      state <= nstate;
      cnt   <= (nstate != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
      if (state == IDLE) begin
        batch <= '0;
        if (start) begin
          m_addr <= message_addr;
          o_addr <= output_addr;
          n_base <= nonce_base;
        end
      end
      if (state == WRITE && nstate == BLK2) batch <= batch + 9'd1;
      // Read data lags the address by one cycle, so slot k lands while cnt = k+1.
      if (state == READ && cnt != 8'd0) hdr[5'(cnt - 8'd1)] <= mem_read_data;
    end
  end

  always_comb begin
    done           = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state)
      READ: if (cnt < 8'd19) mem_addr = m_addr + 16'(cnt);
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = o_addr + 16'(32'(batch) * WR_LEN) + 16'(cnt);
        for (int c = 0; c < NUM_CORES; c++)
          for (int w = 0; w < WPN; w++)
            if (cnt == 8'(c * WPN + w)) mem_write_data = digests[c][w];
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign mid_start  = (state == MID) && (cnt == 8'd0);
  assign core_start = (state == BLK2 || state == HASH2) && (cnt == 8'd0);
  assign core_init  = (state == HASH2) ? IV : mid_h;

  // Dedicated midstate engine: it idles after MID, so mid_h stays valid for every batch.
  sha256_block u_mid (
    .clk    (clk),
    .rst_n  (reset_n),
    .start  (mid_start),
    .init_h (IV),
    .blk    (hdr[15:0]),
    .digest (mid_h)
  );

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic [15:0][31:0] blk;
    always_comb begin
      blk = '0;
      if (state == HASH2) begin
        blk[7:0] = digests[c];
        blk[8]   = 32'h80000000;
        blk[15]  = 32'd256;
      end else begin
        blk[2:0] = hdr[18:16];
        blk[3]   = n_base + 32'(32'(batch) * NUM_CORES + c);
        blk[4]   = 32'h80000000;
        blk[15]  = 32'd640;
      end
    end
    sha256_block u_core (
      .clk    (clk),
      .rst_n  (reset_n),
      .start  (core_start),
      .init_h (core_init),
      .blk    (blk),
      .digest (digests[c])
    );
  end

endmodule

// File: tb/tb_bitcoin_hash_par.sv
// Bench for bitcoin_hash_par: one single-core and one four-core instance run the same jobs
// against a behavioural double-SHA-256 model; covers wrap, restart-ignore and mid-job reset.
module tb_bitcoin_hash_par;

`ifdef BITCOIN_HASH_FULL_DIGEST_EN
  localparam int W = 8;
  localparam int EXP_D0 = 2294;
  localparam int EXP_D1 = 734;
`else
  localparam int W = 1;
  localparam int EXP_D0 = 2182;
  localparam int EXP_D1 = 622;
`endif

  localparam logic [255:0] TIV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [31:0] nb;
    logic [15:0] ma;
    logic [15:0] oa;
    bit          pulse;
    int          exp0;
    int          exp1;
  } vec_t;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [15:0] maddr = '0, oaddr = '0;
  logic [31:0] nbase = '0;
  logic done0, done1, mclk0, mclk1, we0, we1;
  logic [15:0] a0, a1;
  logic [31:0] wd0, wd1, rd0, rd1;

  logic [31:0] hdr_w [19];
  logic [31:0] mem0 [65536];
  logic [31:0] mem1 [65536];
  int tag0 [65536];
  int tag1 [65536];
  int wc0 = 0, wc1 = 0, dn0 = 0, dn1 = 0, dc0 = 0, dc1 = 0;
  int cyc = 0, t0 = 0, job = 0;
  int n_cmp = 0, n_fail = 0;
  int wcs [2];
  int dns [2];
  logic [255:0] g [16];
  vec_t vt [3];

  always #5 clk = ~clk;

  bitcoin_hash_par #(.NUM_NONCES(16), .NUM_CORES(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(maddr), .output_addr(oaddr),
    .nonce_base(nbase), .done(done0), .mem_clk(mclk0), .mem_we(we0), .mem_addr(a0),
    .mem_write_data(wd0), .mem_read_data(rd0));

  bitcoin_hash_par #(.NUM_NONCES(16), .NUM_CORES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(maddr), .output_addr(oaddr),
    .nonce_base(nbase), .done(done1), .mem_clk(mclk1), .mem_we(we1), .mem_addr(a1),
    .mem_write_data(wd1), .mem_read_data(rd1));

  function automatic logic [31:0] hdr_rd(input logic [15:0] a);
    logic [15:0] d;
    d = a - maddr;
    return (d < 16'd19) ? hdr_w[d] : 32'h0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge mclk0) begin
    rd0 <= hdr_rd(a0);
    if (we0) begin mem0[a0] <= wd0; tag0[a0] <= job; wc0 <= wc0 + 1; end
  end
  always @(posedge mclk1) begin
    rd1 <= hdr_rd(a1);
    if (we1) begin mem1[a1] <= wd1; tag1[a1] <= job; wc1 <= wc1 + 1; end
  end
  always @(negedge clk) begin
    if (done0) begin dn0 <= dn0 + 1; dc0 <= cyc - t0 + 1; end
    if (done1) begin dn1 <= dn1 + 1; dc1 <= cyc - t0 + 1; end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
      s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i] + hin[255-32*i -: 32];
    return r;
  endfunction

  function automatic logic [255:0] dhash(input logic [31:0] nonce);
    logic [511:0] m;
    logic [255:0] mid, d1;
    for (int i = 0; i < 16; i++) m[511-32*i -: 32] = hdr_w[i];
    mid = compress(TIV, m);
    d1  = compress(mid, {hdr_w[16], hdr_w[17], hdr_w[18], nonce, 32'h80000000, 320'h0, 32'd640});
    return compress(TIV, {d1, 32'h80000000, 192'h0, 32'd256});
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic kick(input vec_t v);
    @(negedge clk);
    maddr = v.ma; oaddr = v.oa; nbase = v.nb;
    job++;
    wcs[0] = wc0; wcs[1] = wc1; dns[0] = dn0; dns[1] = dn1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic verify(input int k, input int exp_done);
    logic [15:0] ad;
    logic [31:0] gw, got;
    check($sformatf("d%0d_done_count", k), 256'((k == 0 ? dn0 : dn1) - dns[k]), 256'(1));
    check($sformatf("d%0d_done_cycle", k), 256'(k == 0 ? dc0 : dc1), 256'(exp_done));
    check($sformatf("d%0d_write_count", k), 256'((k == 0 ? wc0 : wc1) - wcs[k]), 256'(16 * W));
    for (int i = 0; i < 16; i++)
      for (int w = 0; w < W; w++) begin
        ad = oaddr + 16'(W * i + w);
        gw = g[i][255-32*w -: 32];
        if (k == 0) got = (tag0[ad] == job) ? mem0[ad] : ~gw;
        else        got = (tag1[ad] == job) ? mem1[ad] : ~gw;
        check($sformatf("d%0d_job%0d_n%0d_w%0d", k, job, i, w), 256'(got), 256'(gw));
      end
  endtask

  task automatic run_job(input vec_t v);
    for (int i = 0; i < 16; i++) g[i] = dhash(v.nb + 32'(i));
    kick(v);
    for (int n = 0; n < 4000 && !(dn0 > dns[0] && dn1 > dns[1]); n++) begin
      @(negedge clk);
      start = (v.pulse && (cyc - t0 + 1 == 500)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    verify(0, v.exp0);
    verify(1, v.exp1);
  endtask

  initial begin
    for (int i = 0; i < 19; i++) hdr_w[i] = 32'h01234567 ^ (32'(i) * 32'h9e3779b9);
    vt[0] = '{nb: 32'h00000000, ma: 16'h0100, oa: 16'h1000, pulse: 1'b0, exp0: EXP_D0, exp1: EXP_D1};
    vt[1] = '{nb: 32'hFFFFFFFE, ma: 16'h0100, oa: 16'h2000, pulse: 1'b0, exp0: EXP_D0, exp1: EXP_D1};
    vt[2] = '{nb: 32'h12345678, ma: 16'hFFF0, oa: 16'hFFF8, pulse: 1'b1, exp0: EXP_D0, exp1: EXP_D1};

    // Known-answer check of the reference model: SHA-256("abc").
    check("model_abc", compress(TIV, {32'h61626380, 448'h0, 32'h18}),
          256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    repeat (3) @(negedge clk);
    check("rst_outputs_d0", 256'({done0, we0, a0, wd0}), 256'(0));
    check("rst_outputs_d1", 256'({done1, we1, a1, wd1}), 256'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 3; v++) run_job(vt[v]);

    // Reset during HASH2 of batch 3 (same window for both core counts).
    kick(vt[0]);
    for (int n = 0; n < 1000 && (cyc - t0 + 1 < 560); n++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_we_done_d0", 256'({we0, done0}), 256'(0));
    check("midrst_we_done_d1", 256'({we1, done1}), 256'(0));
    wcs[0] = wc0; wcs[1] = wc1; dns[0] = dn0; dns[1] = dn1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_no_writes", 256'({wc0 - wcs[0], wc1 - wcs[1]}), 256'(0));
    check("midrst_no_done", 256'({dn0 - dns[0], dn1 - dns[1]}), 256'(0));
    run_job(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bitcoin_hash_par.md
# bitcoin_hash_par

Parametrised successor to the single-core nonce hasher. It reads one 19-word block header from shared memory and computes the SHA-256 midstate of header words 0–15 once. It then runs the double SHA-256 for NUM_NONCES nonces on NUM_CORES parallel compression engines and writes each result back through the same single-port memory. It sits beside the memory model as a bus master and is started by the testbench or host controller.

## Interface
- NUM_NONCES, 16, nonces hashed per start; power of two, 1..256
- NUM_CORES, 1, parallel compression engines; power of two, divides NUM_NONCES, 1..16
- clk  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- message_addr  in  16  word address of header word 0
- output_addr  in  16  word address of first result
- nonce_base  in  32  nonce of index 0; sampled with start
- done  out  1  one-cycle pulse at job end
- mem_clk  out  1  equals clk, combinational
- mem_we  out  1  write strobe
- mem_addr  out  16  word address
- mem_write_data  out  32  write data
- mem_read_data  in  32  read data; one cycle after mem_addr

## Operation
- Reset values: done=0, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE, all counters 0.
- IDLE: when start=1, latch message_addr, output_addr and nonce_base, then go to READ. When start=0, stay in IDLE.
- READ (20 cycles): issue addresses message_addr+0..18 and capture words 0..18 into a header buffer one cycle later.
- MID (65 cycles): run 64 rounds over header words 0–15 from the standard IV. The 65th cycle adds the IV into the midstate register.
- BLK2 (65 cycles per batch):
  - Each core c processes nonce index i = batch·NUM_CORES+c.
  - Block words are: header 16–18, nonce_base+i (mod 2^32), 0x80000000, ten zeros, 640.
  - Each core starts from the midstate, and the final cycle adds the midstate back in.
- HASH2 (65 cycles per batch): each core hashes its 8-word digest padded with 0x80000000, six zeros and 256, starting from the IV. The final cycle adds the IV back in.
- WRITE: write results sequentially, core 0 first, one word per cycle with mem_we=1. Word H0 of core c goes to output_addr+i.
- After WRITE, go to BLK2 for the next batch. After the last batch, go to DONE.
- DONE: done=1 for one cycle, then IDLE. If start is still high in the following IDLE cycle, a new job begins.
- start is ignored outside IDLE.
- Address arithmetic is mod 2^16. Nonce arithmetic is mod 2^32, so nonce_base=0xFFFFFFFF with i=1 gives nonce 0.
- mem_we=0 in every state except WRITE.
- Reset asserted mid-job returns to IDLE immediately. No further writes are issued, and the job is not resumed.

## Timing
- Count the cycle in which start is sampled as cycle 0. Let B = NUM_NONCES/NUM_CORES and W = words written per nonce (1, or 8 with the macro).
- done is high in cycle 20+65+B·(130+NUM_CORES·W)+1.
- All cores run the same round in lockstep: one round per cycle, with a 16-word rolling schedule.
- Writes are back-to-back, with no gap between batches' write bursts.

## Configuration
- BITCOIN_HASH_FULL_DIGEST_EN defined:
  - WRITE emits all 8 digest words per nonce, H0..H7, to output_addr+8·i+0..7.
  - The WRITE phase lasts 8·NUM_CORES cycles.
- Undefined: only H0 is written, to output_addr+i.

## Structure
- Package bitcoin_hash_pkg holds:
  - the K[0:63] table and the IV constants;
  - the state enum (IDLE, READ, MID, BLK2, HASH2, WRITE, DONE);
  - the sha256_op and rightrotate functions.
- Sub-module sha256_block:
  - One 64-round compression engine with load, start, round counter and final add-back.
  - Instantiated NUM_CORES times for BLK2/HASH2; one extra instance (or core 0, by implementer's choice) for MID.
  - The top level owns the FSM, the memory port and the header buffer.

## Test plan
- Defaults, standard test header, nonce_base=0:
  - exactly 16 writes to output_addr..+15, each equal to golden H0 for nonces 0..15;
  - done pulses exactly once, in cycle 2182.
- NUM_CORES=4, same stimulus: identical 16 values; done in cycle 20+65+4·134+1=622.
- nonce_base=0xFFFFFFFE, NUM_NONCES=4: results match golden for nonces 0xFFFFFFFE, 0xFFFFFFFF, 0, 1.
- start pulsed again in cycle 500 of a running job: ignored, write count and done timing unchanged.
- reset_n low during HASH2 of batch 3: mem_we=0 and done=0 immediately, state IDLE. A subsequent start reproduces the full golden results.
- With BITCOIN_HASH_FULL_DIGEST_EN, defaults: 128 writes, and words 8·i..8·i+7 match the golden full digest of nonce i.
